// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: captures one frame per rx_valid rising edge into a FWFT circular FIFO
// with sticky overrun. Define SERIAL_RX_FIFO_IRQ_EN to build the fill/overrun interrupt.
module serial_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int IRQ_LEVEL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              irq
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_next;
    logic              r_v_q;
    logic              r_overrun;
    logic              w_overrun_next;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_req;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_wr_req = rx_valid & ~r_v_q;
    assign w_pop    = rd_en & ~w_empty;
    // A pop on a full FIFO frees the slot the incoming frame lands in.
    assign w_wr     = w_wr_req & (~w_full | w_pop);
    assign w_drop   = w_wr_req & w_full & ~w_pop;

    assign w_overrun_next = w_drop | (r_overrun & ~clr_ovr);

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_wr && w_pop)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_q     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_v_q     <= rx_valid;
            r_count   <= w_count_next;
            r_overrun <= w_overrun_next;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {rx_error, rx_data};
    end

    assign rd_data = r_mem[r_rd_ptr][DATA_W-1:0];
    assign rd_err  = r_mem[r_rd_ptr][DATA_W];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

`ifdef SERIAL_RX_FIFO_IRQ_EN
    localparam logic [ADDR_W:0] IRQ_CNT = (ADDR_W+1)'(IRQ_LEVEL);

    logic r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_irq <= 1'b0;
        else
            r_irq <= (w_count_next >= IRQ_CNT) | w_overrun_next;
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed testbench for serial_rx_fifo: reset, capture, overflow, wrap, simultaneous
// write/pop and interrupt behaviour (irq expectations follow SERIAL_RX_FIFO_IRQ_EN).
module tb_serial_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       irq;

    int n_checks;
    int n_errors;

`ifdef SERIAL_RX_FIFO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    serial_rx_fifo #(
        .DATA_W   (8),
        .DEPTH    (16),
        .ADDR_W   (4),
        .IRQ_LEVEL(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .rd_en   (rd_en),
        .clr_ovr (clr_ovr),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overrun (overrun),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx_valid held n cycles, then low for one cycle so the next frame sees a new edge.
    task automatic send(input logic [7:0] d, input logic e, input int n);
        rx_data  = d;
        rx_error = e;
        rx_valid = 1'b1;
        repeat (n) tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic e);
        chk({tag, "_data"}, 32'(rd_data), 32'(d));
        chk({tag, "_err"}, 32'(rd_err), 32'(e));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rd_en    = 1'b0;
        clr_ovr  = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single frame held three cycles yields exactly one entry
        rx_data  = 8'hA5;
        rx_error = 1'b0;
        rx_valid = 1'b1;
        tick();
        chk("single_count_first", 32'(count), 32'd1);
        chk("single_data", 32'(rd_data), 32'hA5);
        chk("single_err", 32'(rd_err), 32'd0);
        tick();
        tick();
        chk("single_count_held", 32'(count), 32'd1);
        rx_valid = 1'b0;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_count_end", 32'(count), 32'd0);

        // Fill, drop, clear and drop-with-clear
        for (int i = 0; i < 16; i++)
            send(8'(i), i[0], 1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_overrun_pre", 32'(overrun), 32'd0);
        chk("fill_irq", 32'(irq), 32'(IRQ_ON));
        send(8'h10, 1'b0, 1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        tick();
        chk("clr_overrun", 32'(overrun), 32'd0);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        tick();
        chk("clr_vs_drop_overrun", 32'(overrun), 32'd1);
        clr_ovr  = 1'b0;
        rx_valid = 1'b0;
        tick();
        chk("clr_vs_drop_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++)
            pop_chk($sformatf("fill_pop%0d", i), 8'(i), i[0]);
        chk("fill_drained_empty", 32'(empty), 32'd1);

        // Async reset with 5 entries stored and overrun still set
        for (int i = 0; i < 5; i++)
            send(8'h40 + 8'(i), 1'b0, 1);
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_overrun", 32'(overrun), 32'd1);
        do_reset();

        // Pointer wrap: 10 in/out, then 10 more spanning the wrap
        for (int i = 0; i < 10; i++)
            send(8'(i), 1'b0, 1);
        for (int i = 0; i < 10; i++)
            pop_chk($sformatf("wrap_a%0d", i), 8'(i), 1'b0);
        for (int i = 0; i < 10; i++)
            send(8'h20 + 8'(i), 1'b1, 1);
        chk("wrap_count", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++)
            pop_chk($sformatf("wrap_b%0d", i), 8'h20 + 8'(i), 1'b1);
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        chk("empty_rd_count", 32'(count), 32'd0);
        chk("empty_rd_empty", 32'(empty), 32'd1);
        // Write and pop together on an empty FIFO: write wins, pop ignored
        rx_data  = 8'h77;
        rx_error = 1'b0;
        rx_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        chk("empty_wr_rd_count", 32'(count), 32'd1);
        tick();
        pop_chk("empty_wr_rd_head", 8'h77, 1'b0);

        // Simultaneous write and pop while full
        for (int i = 0; i < 16; i++)
            send(8'h30 + 8'(i), 1'b0, 1);
        chk("sim_full_pre", 32'(full), 32'd1);
        rx_data  = 8'h55;
        rx_error = 1'b1;
        rx_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        chk("sim_count", 32'(count), 32'd16);
        chk("sim_overrun", 32'(overrun), 32'd0);
        tick();
        for (int i = 1; i < 16; i++)
            pop_chk($sformatf("sim_pop%0d", i), 8'h30 + 8'(i), 1'b0);
        pop_chk("sim_last", 8'h55, 1'b1);
        chk("sim_empty", 32'(empty), 32'd1);

        // Interrupt threshold and overrun term
        for (int i = 0; i < 7; i++)
            send(8'h60 + 8'(i), 1'b0, 1);
        chk("irq_7", 32'(irq), 32'd0);
        rx_data  = 8'h67;
        rx_valid = 1'b1;
        tick();
        chk("irq_8", 32'(irq), 32'(IRQ_ON));
        rx_valid = 1'b0;
        tick();
        pop_chk("irq_pop", 8'h60, 1'b0);
        chk("irq_after_pop", 32'(irq), 32'd0);
        for (int i = 0; i < 10; i++)
            send(8'h70 + 8'(i), 1'b0, 1);
        chk("irq_ovf_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 12; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("irq_low_count", 32'(count), 32'd4);
        chk("irq_ovr_hold", 32'(irq), 32'(IRQ_ON));
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("irq_clr", 32'(irq), 32'd0);
        chk("irq_clr_overrun", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
